collision_checker: RTL and testbench

COLLISION_CHECKER -- requirements
Module: collision_checker

---
 rtl/collision_checker.sv | 89 ++++++++
 tb/tb_collision_checker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/collision_checker.sv
// Tests a 4-block candidate piece against the playfield one block per cycle.
// Results (hit_mask/oob/collide) are valid while done is high and hold until the next accepted start.
module collision_checker #(
  parameter int ROWS        = 20,
  parameter int COLS        = 10,
  parameter int ALLOW_ABOVE = 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [ROWS-1:0][COLS-1:0] field,
  input  logic                      start,
  input  logic [3:0][4:0]           cand_xpos,
  input  logic [3:0][4:0]           cand_ypos,
  output logic                      busy,
  output logic                      done,
  output logic                      collide,
  output logic                      oob,
  output logic [3:0]                hit_mask
);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam logic [5:0] COLS6 = 6'(COLS);
  localparam logic [5:0] ROWS6 = 6'(ROWS);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t         state, state_nxt;
  logic [1:0]     idx;
  logic [3:0][4:0] xq, yq;
  logic           accept;

  logic [4:0]     cx, cy;
  logic           x_ok, y_ok, y_above, in_b, blk_oob, occ, hit;
  logic [XW-1:0]  xs;
  logic [YW-1:0]  ys;

  assign cx      = xq[idx];
  assign cy      = yq[idx];
  assign x_ok    = {1'b0, cx} < COLS6;
  assign y_ok    = {1'b0, cy} < ROWS6;
  // y = 28..31 is a small negative row, i.e. above the top edge
  assign y_above = cy[4:2] == 3'b111;
  assign in_b    = x_ok & y_ok;
  assign blk_oob = ~x_ok | (~y_ok & ~((ALLOW_ABOVE != 0) & y_above));
  // Clamp the index to 0 when out of bounds so field is never read out of range
  assign xs      = in_b ? cx[XW-1:0] : '0;
  assign ys      = in_b ? cy[YW-1:0] : '0;
  assign occ     = in_b & field[ys][xs];
  assign hit     = blk_oob | occ;

  assign accept  = start & ((state == IDLE) | (state == DONE));
  assign busy    = state != IDLE;
  assign done    = state == DONE;
  assign collide = |hit_mask;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CHECK;
      CHECK:   if (idx == 2'd3) state_nxt = DONE;
      DONE:    state_nxt = start ? CHECK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      idx      <= '0;
      xq       <= '0;
      yq       <= '0;
      hit_mask <= '0;
      oob      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        xq       <= cand_xpos;
        yq       <= cand_ypos;
        idx      <= '0;
        hit_mask <= '0;
        oob      <= 1'b0;
      end else if (state == CHECK) begin
        hit_mask[idx] <= hit;
        oob           <= oob | blk_oob;
        idx           <= idx + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_collision_checker.sv
// Directed and randomized checks of collision_checker, one instance per ALLOW_ABOVE setting.
module tb_collision_checker;
  localparam int ROWS = 20;
  localparam int COLS = 10;

  logic                      Clk = 1'b0;
  logic                      Reset;
  logic [ROWS-1:0][COLS-1:0] field;
  logic                      start;
  logic [3:0][4:0]           cand_xpos, cand_ypos;
  logic busy_a, done_a, collide_a, oob_a;
  logic busy_b, done_b, collide_b, oob_b;
  logic [3:0] hit_a, hit_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  collision_checker #(.ROWS(ROWS), .COLS(COLS), .ALLOW_ABOVE(1)) dut_a (
    .Clk(Clk), .Reset(Reset), .field(field), .start(start),
    .cand_xpos(cand_xpos), .cand_ypos(cand_ypos),
    .busy(busy_a), .done(done_a), .collide(collide_a), .oob(oob_a), .hit_mask(hit_a));

  collision_checker #(.ROWS(ROWS), .COLS(COLS), .ALLOW_ABOVE(0)) dut_b (
    .Clk(Clk), .Reset(Reset), .field(field), .start(start),
    .cand_xpos(cand_xpos), .cand_ypos(cand_ypos),
    .busy(busy_b), .done(done_b), .collide(collide_b), .oob(oob_b), .hit_mask(hit_b));

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: classify each block straight from the playfield rules
  function automatic void model(input logic [ROWS-1:0][COLS-1:0] f,
                                input logic [3:0][4:0] xs, input logic [3:0][4:0] ys,
                                input bit allow, output logic [3:0] hm, output logic oo);
    int x, y;
    bit bad;
    hm = '0;
    oo = 1'b0;
    for (int k = 0; k < 4; k++) begin
      x = int'(xs[k]);
      y = int'(ys[k]);
      if (x >= COLS)      bad = 1'b1;
      else if (y >= 28)   bad = !allow;
      else if (y >= ROWS) bad = 1'b1;
      else                bad = 1'b0;
      if (bad) begin
        hm[k] = 1'b1;
        oo    = 1'b1;
      end else if (y < ROWS && f[y][x]) begin
        hm[k] = 1'b1;
      end
    end
  endfunction

  task automatic chk_res(input string tag, input logic [3:0] ea, input logic oa,
                         input logic [3:0] eb, input logic ob);
    chk({tag, " hit_a"}, 32'(hit_a), 32'(ea));
    chk({tag, " oob_a"}, 32'(oob_a), 32'(oa));
    chk({tag, " col_a"}, 32'(collide_a), 32'(|ea));
    chk({tag, " hit_b"}, 32'(hit_b), 32'(eb));
    chk({tag, " oob_b"}, 32'(oob_b), 32'(ob));
    chk({tag, " col_b"}, 32'(collide_b), 32'(|eb));
  endtask

  // One full check started now (cycle N); done expected only in cycle N+5
  task automatic run(input string tag, input logic [3:0] ea, input logic oa,
                     input logic [3:0] eb, input logic ob);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk({tag, " early_done"}, 32'({done_a, done_b}), 32'd0);
      chk({tag, " busy"}, 32'({busy_a, busy_b}), 32'd3);
      step();
    end
    chk({tag, " done"}, 32'({done_a, done_b}), 32'd3);
    chk({tag, " busy_done"}, 32'({busy_a, busy_b}), 32'd3);
    chk_res(tag, ea, oa, eb, ob);
    step();
    chk({tag, " done_after"}, 32'({done_a, done_b}), 32'd0);
    chk({tag, " idle"}, 32'({busy_a, busy_b}), 32'd0);
    chk_res({tag, " hold"}, ea, oa, eb, ob);
  endtask

  task automatic set_blocks(input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2, input int x3, input int y3);
    cand_xpos[0] = 5'(x0); cand_ypos[0] = 5'(y0);
    cand_xpos[1] = 5'(x1); cand_ypos[1] = 5'(y1);
    cand_xpos[2] = 5'(x2); cand_ypos[2] = 5'(y2);
    cand_xpos[3] = 5'(x3); cand_ypos[3] = 5'(y3);
  endtask

  initial begin
    logic [3:0] ea, eb, ta, tb;
    logic oa, ob, toa, tob;
    logic [ROWS-1:0][COLS-1:0] f0;

    Reset = 1'b1; start = 1'b0; field = '0;
    set_blocks(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    chk("reset busy", 32'({busy_a, busy_b}), 32'd0);
    chk("reset done", 32'({done_a, done_b}), 32'd0);
    chk_res("reset", 4'h0, 1'b0, 4'h0, 1'b0);

    // Reset wins over start in the same cycle
    start = 1'b1;
    step();
    start = 1'b0;
    chk("reset_vs_start busy", 32'({busy_a, busy_b}), 32'd0);
    Reset = 1'b0;
    step();

    set_blocks(4, 0, 5, 0, 4, 1, 5, 1);
    run("empty", 4'h0, 1'b0, 4'h0, 1'b0);

    field[19][3] = 1'b1;
    set_blocks(3, 19, 4, 19, 3, 18, 4, 18);
    run("floor_hit", 4'h1, 1'b0, 4'h1, 1'b0);
    field = '0;

    set_blocks(4, 0, 5, 0, 31, 5, 4, 20);
    run("oob_edges", 4'hC, 1'b1, 4'hC, 1'b1);

    set_blocks(4, 31, 5, 0, 4, 1, 5, 1);
    run("above_top", 4'h0, 1'b0, 4'h1, 1'b1);

    set_blocks(9, 19, 10, 19, 9, 27, 0, 28);
    run("corners", 4'h6, 1'b1, 4'hE, 1'b1);

    // Field edits mid-check reach only blocks not yet evaluated; duplicates are independent
    set_blocks(2, 10, 5, 10, 0, 0, 2, 10);
    f0 = '0;
    field = f0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    field[10][2] = 1'b1;
    field[10][5] = 1'b1;
    model(f0, cand_xpos, cand_ypos, 1'b1, ta, toa);
    model(field, cand_xpos, cand_ypos, 1'b1, ea, oa);
    ea[0] = ta[0];
    step(); step(); step();
    chk("live_field done", 32'({done_a, done_b}), 32'd3);
    chk_res("live_field", ea, oa, ea, oa);
    step();
    field = '0;

    // start pulse during CHECK is not queued
    set_blocks(1, 1, 2, 1, 3, 1, 4, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("ignored_start done", 32'({done_a, done_b}), 32'd3);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ignored_start no_extra", 32'({done_a, done_b}), 32'd0);
    end

    // start held high: back-to-back checks at N+5 and N+10
    set_blocks(4, 0, 5, 0, 4, 1, 5, 1);
    start = 1'b1;
    step();
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) begin
        chk("b2b first done", 32'({done_a, done_b}), 32'd3);
        chk_res("b2b first", 4'h0, 1'b0, 4'h0, 1'b0);
        set_blocks(12, 0, 5, 0, 4, 30, 5, 1);
      end else if (c == 10) begin
        chk("b2b second done", 32'({done_a, done_b}), 32'd3);
        chk_res("b2b second", 4'h1, 1'b1, 4'h5, 1'b1);
        start = 1'b0;
      end else begin
        chk("b2b gap", 32'({done_a, done_b}), 32'd0);
      end
      step();
    end
    chk("b2b end idle", 32'({busy_a, busy_b}), 32'd0);

    // Reset at N+3 aborts; start right after release works with normal latency
    field[5][5] = 1'b1;
    set_blocks(5, 5, 31, 0, 0, 0, 0, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("abort busy", 32'({busy_a, busy_b}), 32'd0);
    chk("abort done", 32'({done_a, done_b}), 32'd0);
    chk_res("abort", 4'h0, 1'b0, 4'h0, 1'b0);
    run("post_reset", 4'h3, 1'b1, 4'h3, 1'b1);
    field = '0;

    // Randomized placements against the reference model
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          field[r][c] = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 4; k++) begin
        cand_xpos[k] = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                                  : 5'($urandom_range(0, COLS - 1));
        case ($urandom_range(0, 5))
          0:       cand_ypos[k] = 5'($urandom_range(ROWS, 31));
          1:       cand_ypos[k] = 5'($urandom_range(28, 31));
          default: cand_ypos[k] = 5'($urandom_range(0, ROWS - 1));
        endcase
      end
      model(field, cand_xpos, cand_ypos, 1'b1, ea, oa);
      model(field, cand_xpos, cand_ypos, 1'b0, eb, ob);
      run($sformatf("rand%0d", t), ea, oa, eb, ob);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
